ps2_btnstate: RTL
=================

# ps2_btnstate

- Decodes a raw PS/2 keyboard stream into held-key state for the player and shot logic.
- Synchronises the PS/2 clock and data pins, deserialises 11-bit frames and tracks make/break/extended prefixes.
- Drives the 4-bit `btnstate` bus (up/down/left/right), which the movement block consumes, plus shoot and slow-mode levels.

## Interface
Parameters:
- TIMEOUT_CYC, 20000, idle `clk` cycles after a partial frame before the bit counter is discarded (200 µs at 100 MHz)

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- rst  input  1  asynchronous, active-low reset
- ps2_clk  input  1  raw PS/2 clock pin; asynchronous
- ps2_data  input  1  raw PS/2 data pin; asynchronous
- btnstate  output  4  held keys: [3]=up, [2]=down, [1]=left, [0]=right
- shoot  output  1  Z key (0x1A) held
- slow  output  1  left shift (0x12) held
- byte_valid  output  1  one-cycle pulse: good frame received
- frame_err  output  1  one-cycle pulse: bad start, stop or parity bit

## Operation
- Reset (`rst`=0, asynchronous): all outputs, key state, bit counter, timeout counter and decoder state clear to 0 / IDLE. Synchroniser flops reset to 1.
- Synchroniser: 2-FF chain on each pin. A falling edge is detected when the previous synced `ps2_clk` is 1 and the current one is 0. Data is sampled from synced `ps2_data` in that same cycle.
- Deserialiser: 4-bit counter 0..10, 11-bit shift register.
  - Frame layout: bit0 start (=0), bits 1–8 data LSB first, bit9 odd parity, bit10 stop (=1).
  - On the 11th edge, the counter returns to 0.
  - If start=0, stop=1 and XOR(data, parity)=1: pulse `byte_valid` and pass the byte to the decoder.
  - Otherwise: pulse `frame_err`, discard the byte and force the decoder to IDLE.
- Timeout: when the counter ≠ 0 and TIMEOUT_CYC consecutive cycles pass without an edge, the counter clears to 0. No error pulse. The timeout counter saturates and clears on every edge.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK; transitions happen on valid bytes only.
  - IDLE: 0xE0 → EXT; 0xF0 → BRK; any other code sets the matching normal key, stays IDLE.
  - EXT: 0xF0 → EXT_BRK; 0xE0 → EXT; any other code sets the matching extended key → IDLE.
  - BRK: code clears the matching normal key → IDLE.
  - EXT_BRK: code clears the matching extended key → IDLE.
- Key map:
  - Extended: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
  - Normal: 0x1A shoot, 0x12 slow.
  - Unmapped codes are ignored, but the FSM still returns to IDLE.
- Typematic repeats of a make code re-set an already-set bit with no visible change.
- Opposing keys are not resolved: up+down held gives `btnstate[3:2]`=11; the consumer treats that as no motion.

## Timing
- Edge detection occurs 3 `clk` cycles after the pin edge (2 synchroniser cycles plus the detect cycle).
- `byte_valid`/`frame_err` assert in the cycle after the 11th detected edge, for exactly 1 cycle.
- `btnstate`/`shoot`/`slow` update 1 cycle after `byte_valid`. All outputs are registered.
- Minimum byte spacing supported: 2 `clk` cycles; PS/2 spacing is far larger.
- A reset mid-frame or mid-prefix drops the partial frame and prefix; the next frame decodes from IDLE.
- A timeout and an edge in the same cycle: the edge wins, the bit is captured and the counter advances.

## Configuration
- `PS2_WASD_EN` defined: normal codes 0x1D (W), 0x1B (S), 0x1C (A), 0x23 (D) drive separate held bits. These are ORed with the arrow bits into `btnstate` [3], [2], [1], [0] respectively. An arrow break does not clear a still-held WASD key.
- Undefined: those codes are unmapped and ignored.

## Test plan
- Up-arrow make, E0 75: `btnstate`=1000 two cycles after the second `byte_valid`. Break E0 F0 75: `btnstate`=0000, `frame_err` never pulses.
- Up and left makes, E0 75 then E0 6B: `btnstate`=1010. Then break left, E0 F0 6B: `btnstate`=1000. Then Z make 1A: `shoot`=1 with `btnstate` unchanged.
- Frame carrying 0x75 with even parity, after E0: one `frame_err` pulse, no `byte_valid`, `btnstate` unchanged. The next byte 0x74 is decoded from IDLE and ignored (normal 0x74 is unmapped).
- 4 bits sent, line idle for TIMEOUT_CYC+5 cycles, then full frames E0 72: `btnstate`=0100 with no error pulse.
- Shift held (12), `rst` pulsed low mid-frame: all outputs 0 immediately (asynchronously). A subsequent clean E0 74 gives `btnstate`=0001.
- With `PS2_WASD_EN`: W make 1D plus up make gives `btnstate`[3]=1; an up break alone leaves it 1; W break F0 1D clears it to 0.

Source files
------------

// File: rtl/ps2_btnstate.sv
// ps2_btnstate: decodes a raw PS/2 keyboard stream into held-key levels (arrows, shoot, slow).
// Define PS2_WASD_EN to add W/S/A/D as separately held aliases of the arrow bits.
module ps2_btnstate #(
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] btnstate,
    output logic       shoot,
    output logic       slow,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    logic          r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_tocnt;
    logic          r_byte_valid, r_frame_err;
    logic [7:0]    r_byte;
    state_t        r_state, w_state_next;
    logic [3:0]    r_arrow, w_arrow_next;
    logic          r_shoot, w_shoot_next, r_slow, w_slow_next;
    logic [3:0]    r_btn, w_btn_next;
    logic          w_fall, w_frame_ok, w_timeout;
    logic [10:0]   w_frame;
    logic          w_hit_ext, w_hit_norm, w_make;
`ifdef PS2_WASD_EN
    logic [3:0]    r_wasd, w_wasd_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2} <= '1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall     = r_clk_prev & ~r_clk_s2;
    // Live bit completes the frame: bit0 (start) sits in r_shift[0], stop in w_frame[10].
    assign w_frame    = {r_dat_s2, r_shift};
    assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
    assign w_timeout  = (r_tocnt >= TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_tocnt      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
                r_tocnt <= '0;
                r_shift <= {r_dat_s2, r_shift[9:1]};
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= '0;
                    if (w_frame_ok) begin
                        r_byte_valid <= 1'b1;
                        r_byte       <= w_frame[8:1];
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else begin
                if (r_tocnt != TO_MAX) r_tocnt <= r_tocnt + 1'b1;
                if (r_bitcnt != 4'd0 && w_timeout) r_bitcnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_arrow_next = r_arrow;
        w_shoot_next = r_shoot;
        w_slow_next  = r_slow;
`ifdef PS2_WASD_EN
        w_wasd_next  = r_wasd;
`endif
        w_hit_ext    = 1'b0;
        w_hit_norm   = 1'b0;
        w_make       = 1'b0;
        if (r_frame_err) begin
            w_state_next = S_IDLE;
        end else if (r_byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hE0)      w_state_next = S_EXT;
                    else if (r_byte == 8'hF0) w_state_next = S_BRK;
                    else begin
                        w_hit_norm = 1'b1;
                        w_make     = 1'b1;
                    end
                end
                S_EXT: begin
                    if (r_byte == 8'hF0)      w_state_next = S_EXT_BRK;
                    else if (r_byte == 8'hE0) w_state_next = S_EXT;
                    else begin
                        w_hit_ext    = 1'b1;
                        w_make       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_hit_norm   = 1'b1;
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_hit_ext    = 1'b1;
                    w_state_next = S_IDLE;
                end
            endcase
        end
        if (w_hit_ext) begin
            case (r_byte)
                8'h75:   w_arrow_next[3] = w_make;
                8'h72:   w_arrow_next[2] = w_make;
                8'h6B:   w_arrow_next[1] = w_make;
                8'h74:   w_arrow_next[0] = w_make;
                default: ;
            endcase
        end
        if (w_hit_norm) begin
            case (r_byte)
                8'h1A:   w_shoot_next   = w_make;
                8'h12:   w_slow_next    = w_make;
`ifdef PS2_WASD_EN
                8'h1D:   w_wasd_next[3] = w_make;
                8'h1B:   w_wasd_next[2] = w_make;
                8'h1C:   w_wasd_next[1] = w_make;
                8'h23:   w_wasd_next[0] = w_make;
`endif
                default: ;
            endcase
        end
    end

`ifdef PS2_WASD_EN
    assign w_btn_next = w_arrow_next | w_wasd_next;
`else
    assign w_btn_next = w_arrow_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_arrow <= '0;
            r_shoot <= 1'b0;
            r_slow  <= 1'b0;
            r_btn   <= '0;
`ifdef PS2_WASD_EN
            r_wasd  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_arrow <= w_arrow_next;
            r_shoot <= w_shoot_next;
            r_slow  <= w_slow_next;
            r_btn   <= w_btn_next;
`ifdef PS2_WASD_EN
            r_wasd  <= w_wasd_next;
`endif
        end
    end

    assign btnstate   = r_btn;
    assign shoot      = r_shoot;
    assign slow       = r_slow;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;

endmodule
